dds_freq_sched: RTL

//  Frequency-word scheduler for the DDS core. Owns the 24-bit tuning word K, which is also the phase-accumulator increment.

---
 rtl/dds_freq_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dds_freq_sched.sv
// dds_freq_sched
//   Frequency-word scheduler for the DDS core. Owns the tuning word K (the
//   phase-accumulator increment) and publishes every new value over a
//   valid/ready handshake.
//   Manual mode: inc/dec pulses step K by a decade step chosen by step_idx.
//   Sweep mode:  K ramps from sweep_start to sweep_stop by sweep_step, each
//                point held for 'dwell' cycles after it has been accepted.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   inc_pulse     one-cycle increase request (manual mode only)
//   dec_pulse     one-cycle decrease request (manual mode only)
//   step_pulse    one-cycle request to advance step_idx (0..5, wraps)
//   sweep_en      level; rising edge starts a sweep, low aborts one
//   sweep_start   first K of the sweep
//   sweep_stop    last K of the sweep
//   sweep_step    K increment per sweep point (0 behaves as 1)
//   dwell         hold cycles per sweep point (0 behaves as 1)
//   k_ready       DDS core accepts k_out this cycle
//   k_out         current tuning word
//   k_valid       k_out is new and not yet accepted
//   step_idx      manual step index selecting 1,10,100,1e3,1e4,1e5
//   sweeping      high while a sweep is in progress
//   sweep_done    one-cycle pulse once sweep_stop has been accepted

module dds_freq_sched #(
  parameter int            KW      = 24,
  parameter logic [KW-1:0] MIN_K   = KW'(1),
  parameter logic [KW-1:0] MAX_K   = {KW{1'b1}},
  parameter int            DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_pulse,
  input  logic               dec_pulse,
  input  logic               step_pulse,
  input  logic               sweep_en,
  input  logic [KW-1:0]      sweep_start,
  input  logic [KW-1:0]      sweep_stop,
  input  logic [KW-1:0]      sweep_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               k_ready,
  output logic [KW-1:0]      k_out,
  output logic               k_valid,
  output logic [2:0]         step_idx,
  output logic               sweeping,
  output logic               sweep_done
);

  localparam int KW1 = KW + 1;

  typedef enum logic [1:0] {MANUAL, SW_PUB, SW_DWELL} state_t;

  state_t             state, state_nxt;
  logic [KW-1:0]      k_nxt, stop_q, stop_nxt, step_q, step_nxt;
  logic [KW-1:0]      start_c, stop_c;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt, cnt_q, cnt_nxt;
  logic [2:0]         idx_nxt;
  logic               valid_nxt, done_nxt, up_q, up_nxt, arm_q, arm_nxt, en_q;
  logic               stall, transfer;
  logic [KW:0]        k_w, min_w, max_w, stop_w, sstep_w, man_step;
  logic [KW:0]        man_up, man_dn, sw_up, sw_dn;

  function automatic logic [KW:0] decade(input logic [2:0] idx);
    case (idx)
      3'd0:    decade = KW1'(1);
      3'd1:    decade = KW1'(10);
      3'd2:    decade = KW1'(100);
      3'd3:    decade = KW1'(1000);
      3'd4:    decade = KW1'(10000);
      default: decade = KW1'(100000);
    endcase
  endfunction

  // Comparisons are done one bit wider so a full-range MAX_K never turns
  // into a constant comparison.
  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] v);
    logic [KW:0] w;
    w = {1'b0, v};
    if (w < {1'b0, MIN_K})      clamp_k = MIN_K;
    else if (w > {1'b0, MAX_K}) clamp_k = MAX_K;
    else                        clamp_k = v;
  endfunction

  assign stall    = k_valid & ~k_ready;
  assign transfer = k_valid & k_ready;
  assign sweeping = (state != MANUAL);

  assign start_c  = clamp_k(sweep_start);
  assign stop_c   = clamp_k(sweep_stop);

  // All K arithmetic is one bit wider than K so carries and borrows are
  // visible before saturating; nothing ever wraps.
  assign k_w      = {1'b0, k_out};
  assign min_w    = {1'b0, MIN_K};
  assign max_w    = {1'b0, MAX_K};
  assign stop_w   = {1'b0, stop_q};
  assign sstep_w  = {1'b0, step_q};
  assign man_step = decade(step_idx);
  assign man_up   = (k_w + man_step > max_w) ? max_w : k_w + man_step;
  assign man_dn   = (k_w < min_w + man_step) ? min_w : k_w - man_step;
  assign sw_up    = (k_w + sstep_w > stop_w) ? stop_w : k_w + sstep_w;
  assign sw_dn    = (k_w < stop_w + sstep_w) ? stop_w : k_w - sstep_w;

  // Next-state logic. k_valid defaults to "still pending unless accepted";
  // any new word overrides that. Nothing that changes k_out may fire while
  // a word is stalled, which is how stalled requests get dropped.
  always_comb begin
    state_nxt = state;
    k_nxt     = k_out;
    valid_nxt = k_valid & ~k_ready;
    idx_nxt   = step_idx;
    done_nxt  = 1'b0;
    arm_nxt   = arm_q;
    stop_nxt  = stop_q;
    step_nxt  = step_q;
    dwell_nxt = dwell_q;
    cnt_nxt   = cnt_q;
    up_nxt    = up_q;

    if (step_pulse)
      idx_nxt = (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;

    // A rising edge of sweep_en arms a start that waits until no word is
    // stalled; dropping sweep_en disarms it.
    if (!sweep_en)  arm_nxt = 1'b0;
    else if (!en_q) arm_nxt = 1'b1;

    case (state)
      MANUAL: begin
        if (arm_q && sweep_en && !stall) begin
          state_nxt = SW_PUB;
          k_nxt     = start_c;
          valid_nxt = 1'b1;
          arm_nxt   = 1'b0;
          stop_nxt  = stop_c;
          step_nxt  = (sweep_step == '0) ? KW'(1) : sweep_step;
          dwell_nxt = (dwell == '0) ? DWELL_W'(1) : dwell;
          up_nxt    = (start_c <= stop_c);
        end else if (!stall && (inc_pulse ^ dec_pulse)) begin
          if (inc_pulse && k_w != max_w) begin
            k_nxt     = man_up[KW-1:0];
            valid_nxt = 1'b1;
          end else if (dec_pulse && k_w != min_w) begin
            k_nxt     = man_dn[KW-1:0];
            valid_nxt = 1'b1;
          end
        end
      end
      SW_PUB: begin
        if (!sweep_en) begin
          state_nxt = MANUAL;
        end else if (transfer) begin
          if (k_out == stop_q) begin
            done_nxt  = 1'b1;
            state_nxt = MANUAL;
          end else begin
            state_nxt = SW_DWELL;
            cnt_nxt   = dwell_q;
          end
        end
      end
      SW_DWELL: begin
        if (!sweep_en) begin
          state_nxt = MANUAL;
        end else if (cnt_q <= DWELL_W'(1)) begin
          k_nxt     = up_q ? sw_up[KW-1:0] : sw_dn[KW-1:0];
          valid_nxt = 1'b1;
          state_nxt = SW_PUB;
        end else begin
          cnt_nxt = cnt_q - DWELL_W'(1);
        end
      end
      default: state_nxt = MANUAL;
    endcase
  end

  // en_q follows sweep_en during reset so a level held through reset is
  // not mistaken for a fresh start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MANUAL;
      k_out      <= MIN_K;
      k_valid    <= 1'b1;
      step_idx   <= 3'd0;
      sweep_done <= 1'b0;
      arm_q      <= 1'b0;
      en_q       <= sweep_en;
      stop_q     <= MIN_K;
      step_q     <= KW'(1);
      dwell_q    <= DWELL_W'(1);
      cnt_q      <= '0;
      up_q       <= 1'b1;
    end else begin
      state      <= state_nxt;
      k_out      <= k_nxt;
      k_valid    <= valid_nxt;
      step_idx   <= idx_nxt;
      sweep_done <= done_nxt;
      arm_q      <= arm_nxt;
      en_q       <= sweep_en;
      stop_q     <= stop_nxt;
      step_q     <= step_nxt;
      dwell_q    <= dwell_nxt;
      cnt_q      <= cnt_nxt;
      up_q       <= up_nxt;
    end
  end

endmodule
